// File: rtl/seq_det_if.sv
// Control/serial-data bundle for the programmable pattern detector.
// The master side drives configuration, control and serial bits; the slave side returns status.
interface seq_det_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_thresh;
  logic               start;
  logic               stop;
  logic               bit_valid;
  logic               bit_in;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               done;
  logic               cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    output start, stop, bit_valid, bit_in,
    input  busy, match, match_cnt, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    input  start, stop, bit_valid, bit_in,
    output busy, match, match_cnt, done, cfg_err
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run-time programmable serial pattern detector with IDLE/RUN/DONE sequencer,
// match counter and threshold termination. All outputs are registered.
module seq_det_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1,
  parameter int unsigned CNT_W   = 8
) (
  input logic     clk,
  input logic     rst,
  seq_det_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [CNT_W-1:0]   thr_q, thr_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   seen_q, seen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] new_hist;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     seen_inc;
  logic [CNT_W-1:0]   cnt_plus;
  logic               hit;
  logic               cfg_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= LEN_W'(1);
      ovl_q   <= 1'b1;
      thr_q   <= '0;
      hist_q  <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      thr_q   <= thr_d;
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    thr_d    = thr_q;
    hist_d   = hist_q;
    seen_d   = seen_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    match_d  = 1'b0;
    mask     = '0;

    new_hist = {hist_q[MAX_LEN-2:0], bus.bit_in};
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < 32'(len_q));
    end
    // Hit is judged on the history as it will be after this bit is shifted in.
    seen_inc  = {1'b0, seen_q} + (LEN_W+1)'(1);
    hit       = (seen_inc >= {1'b0, len_q}) && ((new_hist & mask) == (pat_q & mask));
    cnt_plus  = cnt_q + CNT_W'(1);
    cfg_legal = (bus.cfg_len != '0) && (32'(bus.cfg_len) <= MAX_LEN);

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_we) begin
          if (cfg_legal) begin
            pat_d = bus.cfg_pattern;
            len_d = bus.cfg_len;
            ovl_d = bus.cfg_overlap;
            thr_d = bus.cfg_thresh;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.start && !err_q) begin
          state_d = S_RUN;
          cnt_d   = '0;
          hist_d  = '0;
          seen_d  = '0;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.bit_valid) begin
          hist_d = new_hist;
          if (32'(seen_q) < MAX_LEN) seen_d = seen_q + LEN_W'(1);
          if (hit) begin
            match_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_plus;
            if (!ovl_q) seen_d = '0;
            if ((thr_q != '0) && (cnt_plus == thr_q)) state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          hist_d  = '0;
          seen_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.match     = match_q;
  assign bus.match_cnt = cnt_q;
  assign bus.done      = done_q;
  assign bus.cfg_err   = err_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_seq_det_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned npass = 0;
  int unsigned ntotal = 0;

  always #5 clk = ~clk;

  seq_det_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus ();

  seq_det_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] th);
    bus.cfg_we = 1'b1; bus.cfg_pattern = p; bus.cfg_len = l;
    bus.cfg_overlap = ov; bus.cfg_thresh = th;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; tick(); bus.stop = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_valid = 1'b1; bus.bit_in = b;
    tick();
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic gap3();
    tick(); tick(); tick();
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
    bus.cfg_overlap = 1'b0; bus.cfg_thresh = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_busy", bus.busy, 0);
    chk("rst_match", bus.match, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.cfg_err, 0);

    // Overlapping detection of 1011 in 1,0,1,1,0,1,1
    cfg(8'b1011, 4'd4, 1'b1, 8'd0);
    chk("ov_cfg_err", bus.cfg_err, 0);
    pulse_start();
    chk("ov_busy", bus.busy, 1);
    send_bit(1); send_bit(0); send_bit(1);
    chk("ov_nomatch3", bus.match, 0);
    send_bit(1);
    chk("ov_match4", bus.match, 1);
    chk("ov_cnt4", bus.match_cnt, 1);
    send_bit(0);
    chk("ov_pulse_end", bus.match, 0);
    send_bit(1); send_bit(1);
    chk("ov_match7", bus.match, 1);
    chk("ov_cnt7", bus.match_cnt, 2);
    chk("ov_busy7", bus.busy, 1);
    pulse_stop();
    chk("ov_stop_idle", bus.busy, 0);
    chk("ov_stop_cnt", bus.match_cnt, 2);

    // Non-overlapping: only the first occurrence counts
    cfg(8'b1011, 4'd4, 1'b0, 8'd0);
    pulse_start();
    chk("no_cnt_clr", bus.match_cnt, 0);
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("no_match4", bus.match, 1);
    send_bit(0); send_bit(1); send_bit(1);
    chk("no_match7", bus.match, 0);
    chk("no_cnt7", bus.match_cnt, 1);
    pulse_stop();

    // Threshold of 2 terminates in the cycle of the second pulse
    cfg(8'b1011, 4'd4, 1'b1, 8'd2);
    pulse_start();
    send_bit(1); send_bit(0); send_bit(1); send_bit(1);
    chk("th_cnt4", bus.match_cnt, 1);
    chk("th_done4", bus.done, 0);
    send_bit(0); send_bit(1); send_bit(1);
    chk("th_match7", bus.match, 1);
    chk("th_done7", bus.done, 1);
    chk("th_busy7", bus.busy, 0);
    chk("th_cnt7", bus.match_cnt, 2);
    send_bit(0); send_bit(1); send_bit(1);
    chk("th_hold_match", bus.match, 0);
    chk("th_hold_cnt", bus.match_cnt, 2);
    pulse_start();
    chk("th_restart_busy", bus.busy, 1);
    chk("th_restart_done", bus.done, 0);
    chk("th_restart_cnt", bus.match_cnt, 0);
    pulse_stop();

    // Illegal lengths, blocked start, write+start in one cycle
    cfg(8'b0, 4'd0, 1'b1, 8'd0);
    chk("ill_len0_err", bus.cfg_err, 1);
    pulse_start();
    chk("ill_start_blocked", bus.busy, 0);
    cfg(8'b0, 4'd9, 1'b1, 8'd0);
    chk("ill_len9_err", bus.cfg_err, 1);
    bus.start = 1'b1;
    cfg(8'b1011, 4'd4, 1'b1, 8'd0);
    bus.start = 1'b0;
    chk("wr_start_err", bus.cfg_err, 0);
    chk("wr_start_idle", bus.busy, 0);
    pulse_start();
    chk("legal_start_busy", bus.busy, 1);

    // Gapped stream gives the same result as a continuous one
    send_bit(1); gap3(); send_bit(0); gap3(); send_bit(1); gap3(); send_bit(1);
    chk("gap_match4", bus.match, 1);
    tick();
    chk("gap_pulse_end", bus.match, 0);
    gap3(); send_bit(0); gap3(); send_bit(1); gap3(); send_bit(1);
    chk("gap_match7", bus.match, 1);
    chk("gap_cnt7", bus.match_cnt, 2);

    // Write during RUN must not retarget to 0110 (history now ...1011)
    cfg(8'b0110, 4'd4, 1'b1, 8'd0);
    chk("run_wr_err", bus.cfg_err, 0);
    send_bit(0);
    chk("run_wr_nomatch", bus.match, 0);
    send_bit(1); send_bit(1);
    chk("run_wr_oldpat", bus.match, 1);
    chk("run_wr_cnt", bus.match_cnt, 3);

    // Stop with a completing bit: bit discarded, count retained
    send_bit(1); send_bit(0); send_bit(1);
    bus.stop = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick();
    bus.stop = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    chk("stop_nomatch", bus.match, 0);
    chk("stop_idle", bus.busy, 0);
    chk("stop_cnt", bus.match_cnt, 3);

    // Reset mid-run alongside the completing bit
    pulse_start();
    send_bit(1); send_bit(0); send_bit(1);
    rst = 1'b1; bus.bit_valid = 1'b1; bus.bit_in = 1'b1;
    tick();
    rst = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    chk("mrst_match", bus.match, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_cnt", bus.match_cnt, 0);
    chk("mrst_done", bus.done, 0);
    tick();
    chk("mrst_match_after", bus.match, 0);
    cfg(8'b1011, 4'd4, 1'b1, 8'd0);
    pulse_start();
    send_bit(1);
    chk("mrst_stale_hist", bus.match, 0);
    send_bit(0); send_bit(1); send_bit(1);
    chk("mrst_fresh_match", bus.match, 1);
    chk("mrst_fresh_cnt", bus.match_cnt, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run-time programmable serial pattern detector with its own control sequencer. It configures the match pattern, length, overlap mode and match threshold, then arms and runs detection on a qualified serial bit stream. While running it counts matches and terminates on a threshold. It sits between the host control registers and the serial input path, replacing hard-coded single-pattern FSM detectors.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, $clog2(MAX_LEN)+1, width of the length field
CNT_W, 8, width of the match counter and threshold

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_we  in  1  configuration write strobe (honoured in IDLE only)
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first serial bit, bit [0] is the last
cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
cfg_thresh  in  CNT_W  match count that terminates a run; 0 = never terminate
start  in  1  start pulse
stop  in  1  abort pulse
bit_valid  in  1  bit_in qualifier
bit_in  in  1  serial data bit
busy  out  1  high in RUN
match  out  1  one-cycle match pulse
match_cnt  out  CNT_W  matches counted in the current or last run
done  out  1  high in DONE
cfg_err  out  1  last configuration write was illegal

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state IDLE.
  - Outputs: busy=0, match=0, match_cnt=0, done=0, cfg_err=0.
  - Config registers: pattern=0, len=1, overlap=1, thresh=0.
  - Internal history and bits_seen are cleared.
  - Reset mid-run aborts immediately. No match pulse appears in the cycle after reset.
- States: IDLE, RUN, DONE. State is registered; there is no combinational path from bit_in to any output.
- IDLE, configuration writes:
  - cfg_we with cfg_len in 1..MAX_LEN: all four config fields are loaded and cfg_err is cleared.
  - cfg_we with cfg_len=0 or cfg_len>MAX_LEN: config is unchanged and cfg_err is set to 1.
  - cfg_we in RUN or DONE is ignored.
- IDLE, start:
  - start with cfg_err=0: next state is RUN. match_cnt, history and bits_seen are cleared.
  - start with cfg_err=1: ignored.
  - cfg_we and start in the same cycle: the write is applied and start is ignored.
- RUN, on each cycle with bit_valid=1:
  - History update: hist <= {hist[MAX_LEN-2:0], bit_in}.
  - bits_seen increments and saturates at MAX_LEN.
  - Hit condition: (bits_seen+1) >= len AND new hist[len-1:0] == pattern[len-1:0].
- RUN, on a hit:
  - match=1 in the following cycle; match_cnt is incremented in that same cycle (latency 1).
  - If overlap=0, bits_seen is cleared, so the next match needs len fresh bits.
- RUN, bit_valid=0: no state change; the history is held across gaps.
- RUN, termination and abort:
  - A hit with thresh!=0 and match_cnt+1==thresh: next state is DONE, concurrent with the match pulse.
  - With thresh=0, match_cnt saturates at 2^CNT_W-1 and RUN continues.
  - stop: next state is IDLE. stop has priority over a same-cycle bit, which is discarded (no hit). match_cnt is retained.
  - start while in RUN is ignored.
- DONE:
  - done=1; bits are ignored; match_cnt is held.
  - start restarts: RUN, count and history cleared.
  - stop: IDLE.
  - start and stop in the same cycle: stop wins.
- busy=1 exactly in RUN; done=1 exactly in DONE. Both are registered from state.

Test Plan:
- Overlap hit: cfg pattern=4'b1011, len=4, overlap=1, thresh=0; start; bits 1,0,1,1,0,1,1 (continuous valid) -> match pulses one cycle after bits 4 and 7; match_cnt=2; busy stays 1.
- Non-overlap: same config with overlap=0 and the same stream -> a single match after bit 4; match_cnt=1.
- Threshold and restart: thresh=2, overlap=1; bits 1,0,1,1,0,1,1 -> DONE with done=1 and busy=0 in the cycle of the 2nd match pulse; further bits do not change match_cnt=2; start -> RUN with match_cnt=0.
- Illegal config: cfg_len=0 -> cfg_err=1 and the old config is kept; start stays in IDLE; a legal write then clears cfg_err and start enters RUN.
- Gaps, stop and ignored writes: the 1011 stream with bit_valid low for 3 cycles between bits -> identical match count. stop asserted with a valid completing bit -> no match, IDLE, count retained. cfg_we during RUN -> pattern unchanged.
- Reset mid-run: rst asserted in RUN after 3 of 4 pattern bits -> next cycle all outputs 0 and state IDLE; the old partial history does not produce a match after restart.
